fht_bank_wr: RTL and testbench
==============================

Name: fht_bank_wr

Overview:
- Write-back controller on the output side of the double-butterfly block in the FHT datapath.
- Accepts the four reordered butterfly results each valid cycle and drives one write port per RAM bank (bank 0..3, shared address).
- Optionally scales the data by 1/2 and detects near-overflow for block-floating scaling of the next stage.
- Generates write addresses (linear, or bit-reversed on the last stage) and signals stage completion to the sequencer.

Parameters:
- D_BIT, 17, data word width (signed, two's complement).
- A_BIT, 8, bank address width; one stage = 2^A_BIT write cycles.

Ports:
- iCLK  in  1  clock, rising edge.
- iRESET  in  1  asynchronous active-low reset.
- iSTART  in  1  one-cycle pulse: begin a stage write-back.
- iST_LAST  in  1  sampled on accepted iSTART: stage is the final stage.
- iSCALE  in  1  sampled on accepted iSTART: apply 1/2 scaling for this stage.
- iVALID  in  1  iY_0..iY_3 carry a valid result set this cycle.
- iY_0, iY_1, iY_2, iY_3  in  D_BIT each  signed butterfly results for banks 0..3.
- oWR_EN  out  1  bank write strobe, common to all 4 banks.
- oWR_ADDR  out  A_BIT  bank write address.
- oDATA_0, oDATA_1, oDATA_2, oDATA_3  out  D_BIT each  write data for banks 0..3.
- oBUSY  out  1  high in RUN and DONE.
- oSTAGE_DONE  out  1  one-cycle pulse after the last write of a stage.
- oOVF  out  1  sticky near-overflow flag for the current stage.

Behaviour:
- Reset (async, iRESET=0): state IDLE, counter 0. oWR_EN, oWR_ADDR, oDATA_*, oBUSY, oSTAGE_DONE, oOVF all 0. The latched last and scale flags are 0. Reset mid-stage aborts with no further writes.
- States:
  - IDLE -> RUN on iSTART: counter=0, oOVF cleared, iST_LAST and iSCALE latched.
  - RUN -> DONE on the accepted iVALID with counter = 2^A_BIT-1.
  - DONE -> IDLE after one cycle.
- In IDLE and DONE: iVALID is ignored and oWR_EN stays 0.
- In RUN and DONE: iSTART is ignored.
- In RUN, each iVALID:
  - next cycle, oWR_EN=1 and oDATA_k = f(iY_k);
  - oWR_ADDR = counter if the latched last flag is 0, else counter bit-reversed over A_BIT bits;
  - counter increments and wraps to 0 after 2^A_BIT-1.
- Latency: iVALID to oWR_EN is exactly 1 cycle. Gaps in iVALID are allowed; writes occur only for valid cycles. oWR_EN is 0 in cycles without a registered valid.
- oDATA_* and oWR_ADDR hold their last value when oWR_EN=0.
- oSTAGE_DONE is asserted in DONE, coincident with the final oWR_EN. oBUSY is 1 in RUN and DONE.
- f(y):
  - scale=0: y unchanged.
  - scale=1: (y + 1) >>> 1, arithmetic shift, round half up. The sum is computed in D_BIT+1 bits; the result always fits D_BIT.
- Overflow: oOVF is set in the cycle after any accepted iVALID where some iY_k has y[D_BIT-1] != y[D_BIT-2]. The check uses the unscaled input. oOVF holds until the next accepted iSTART, including through IDLE.
- iSTART coinciding with iVALID in IDLE: the start is taken, and that iVALID is ignored.

Test Plan:
- Linear stage: iSTART (last=0, scale=0), then 256 consecutive iVALID with iY_k = 4*n+k -> writes at addr 0..255 with oDATA_k = 4*n+k. oSTAGE_DONE high with the addr-255 write, then oBUSY=0.
- Last stage with bit-reverse: last=1, counter 1 -> oWR_ADDR=0x80; counter 3 -> 0xC0; counter 254 -> 0x7F.
- Scaling: scale=1, iY = 5, -5, 65535, -65536 -> oDATA = 3, -2, 32768, -32768.
- Overflow: one input of 0x08000 (bits 16:15 = 01) at n=10 -> oOVF=1 from the next cycle, held after DONE. The next iSTART clears it. Inputs limited to ±32767 leave oOVF=0.
- Gapped valid and ignored starts: iVALID every other cycle plus an iSTART pulse mid-RUN -> addresses stay contiguous, oWR_EN only after valid cycles. iVALID in IDLE produces no writes.
- Reset mid-operation: assert iRESET at counter=100 -> all outputs 0 immediately. A new iSTART restarts the stage at addr 0.

Source files
------------

// File: rtl/fht_bank_wr.sv
// Write-back controller behind the FHT double butterfly: it registers four results per valid
// cycle into banks 0..3 at a shared address and does optional 1/2 scaling and overflow flagging.
module fht_bank_wr #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 8
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iST_LAST,
    input  logic             iSCALE,
    input  logic             iVALID,
    input  logic [D_BIT-1:0] iY_0,
    input  logic [D_BIT-1:0] iY_1,
    input  logic [D_BIT-1:0] iY_2,
    input  logic [D_BIT-1:0] iY_3,
    output logic             oWR_EN,
    output logic [A_BIT-1:0] oWR_ADDR,
    output logic [D_BIT-1:0] oDATA_0,
    output logic [D_BIT-1:0] oDATA_1,
    output logic [D_BIT-1:0] oDATA_2,
    output logic [D_BIT-1:0] oDATA_3,
    output logic             oBUSY,
    output logic             oSTAGE_DONE,
    output logic             oOVF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [A_BIT-1:0]        cnt_reg, cnt_next;
    logic                    last_reg, last_next;
    logic                    scale_reg, scale_next;
    logic                    ovf_reg, ovf_next;
    logic                    wr_en_reg, wr_en_next;
    logic [A_BIT-1:0]        addr_reg, addr_next;
    logic [3:0][D_BIT-1:0]   data_reg, data_next;

    logic [3:0][D_BIT-1:0]   y_in;
    logic [3:0][D_BIT-1:0]   f_val;
    logic [3:0]              near_ovf;
    logic [A_BIT-1:0]        cnt_rev;

    assign y_in[0] = iY_0;
    assign y_in[1] = iY_1;
    assign y_in[2] = iY_2;
    assign y_in[3] = iY_3;

    // Per-bank datapath: rounding halve in D_BIT+1 bits, near-overflow on the unscaled input.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic [D_BIT:0] sum;
            assign sum          = {y_in[gi][D_BIT-1], y_in[gi]} + (D_BIT+1)'(1);
            assign f_val[gi]    = scale_reg ? sum[D_BIT:1] : y_in[gi];
            assign near_ovf[gi] = y_in[gi][D_BIT-1] ^ y_in[gi][D_BIT-2];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < A_BIT; gi++) begin : g_rev
            assign cnt_rev[gi] = cnt_reg[A_BIT-1-gi];
        end
    endgenerate

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b0;
            scale_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            wr_en_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            scale_reg <= scale_next;
            ovf_reg   <= ovf_next;
            wr_en_reg <= wr_en_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        scale_next = scale_reg;
        ovf_next   = ovf_reg;
        wr_en_next = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                // A start takes priority; a coincident valid is dropped.
                if (iSTART) begin
                    state_next = RUN;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    last_next  = iST_LAST;
                    scale_next = iSCALE;
                end
            end
            RUN: begin
                if (iVALID) begin
                    wr_en_next = 1'b1;
                    addr_next  = last_reg ? cnt_rev : cnt_reg;
                    data_next  = f_val;
                    if (|near_ovf) begin
                        ovf_next = 1'b1;
                    end
                    cnt_next = cnt_reg + A_BIT'(1);
                    if (&cnt_reg) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign oWR_EN      = wr_en_reg;
    assign oWR_ADDR    = addr_reg;
    assign oDATA_0     = data_reg[0];
    assign oDATA_1     = data_reg[1];
    assign oDATA_2     = data_reg[2];
    assign oDATA_3     = data_reg[3];
    assign oBUSY       = (state_reg != IDLE);
    assign oSTAGE_DONE = (state_reg == DONE);
    assign oOVF        = ovf_reg;

endmodule

// File: tb/tb_fht_bank_wr.sv
// Bench for fht_bank_wr: a stage-level reference model plus table vectors and targeted sequences.
module tb_fht_bank_wr;

    localparam int D = 17;
    localparam int A = 8;
    localparam int N = 1 << A;

    logic iCLK = 1'b0;
    logic iRESET = 1'b1;
    logic iSTART = 1'b0, iST_LAST = 1'b0, iSCALE = 1'b0, iVALID = 1'b0;
    logic signed [D-1:0] iY_0 = '0, iY_1 = '0, iY_2 = '0, iY_3 = '0;
    logic oWR_EN;
    logic [A-1:0] oWR_ADDR;
    logic signed [D-1:0] oDATA_0, oDATA_1, oDATA_2, oDATA_3;
    logic oBUSY, oSTAGE_DONE, oOVF;

    fht_bank_wr #(.D_BIT(D), .A_BIT(A)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iST_LAST(iST_LAST),
        .iSCALE(iSCALE), .iVALID(iVALID),
        .iY_0(iY_0), .iY_1(iY_1), .iY_2(iY_2), .iY_3(iY_3),
        .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR),
        .oDATA_0(oDATA_0), .oDATA_1(oDATA_1), .oDATA_2(oDATA_2), .oDATA_3(oDATA_3),
        .oBUSY(oBUSY), .oSTAGE_DONE(oSTAGE_DONE), .oOVF(oOVF)
    );

    always #5 iCLK = ~iCLK;

    int nchk = 0;
    int nerr = 0;

    // Reference model: in_stage/finishing describe the stage, writes counts results taken so far.
    bit m_in_stage, m_finishing, m_last, m_scale, m_ovf, e_wr;
    int m_writes, e_addr;
    int e_data[4];

    typedef struct { int y; int exp_data; } scale_vec_t;
    typedef struct { int n; int exp_addr; } rev_vec_t;
    scale_vec_t scale_tab[4];
    rev_vec_t   rev_tab[3];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int n);
        int r = 0;
        for (int i = 0; i < A; i++)
            if (((n >> i) & 1) == 1) r += 1 << (A - 1 - i);
        return r;
    endfunction

    function automatic int fscale(input int y, input bit s);
        int t;
        if (!s) return y;
        t = y + 1;
        return (t >= 0) ? t / 2 : -((1 - t) / 2);  // floor((y+1)/2)
    endfunction

    function automatic bit near(input int y);
        return (y > 32767) || (y < -32768);
    endfunction

    function automatic int rand_y(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic model_reset();
        m_in_stage = 0; m_finishing = 0; m_last = 0; m_scale = 0; m_ovf = 0;
        e_wr = 0; m_writes = 0; e_addr = 0;
        for (int k = 0; k < 4; k++) e_data[k] = 0;
    endtask

    task automatic model_step(input bit st, input bit last, input bit sc, input bit v,
                              input int y0, input int y1, input int y2, input int y3);
        int ys[4];
        ys[0] = y0; ys[1] = y1; ys[2] = y2; ys[3] = y3;
        e_wr = 0;
        if (m_finishing) begin
            m_finishing = 0;
        end else if (m_in_stage) begin
            if (v) begin
                e_wr = 1;
                e_addr = m_last ? bitrev(m_writes) : m_writes;
                for (int k = 0; k < 4; k++) begin
                    e_data[k] = fscale(ys[k], m_scale);
                    if (near(ys[k])) m_ovf = 1;
                end
                m_writes++;
                if (m_writes == N) begin
                    m_in_stage = 0;
                    m_finishing = 1;
                    m_writes = 0;
                end
            end
        end else if (st) begin
            m_in_stage = 1; m_writes = 0; m_ovf = 0; m_last = last; m_scale = sc;
        end
    endtask

    task automatic check_all();
        chk("wr_en", int'(oWR_EN), int'(e_wr));
        chk("busy", int'(oBUSY), int'(m_in_stage | m_finishing));
        chk("stage_done", int'(oSTAGE_DONE), int'(m_finishing));
        chk("ovf", int'(oOVF), int'(m_ovf));
        chk("wr_addr", int'(oWR_ADDR), e_addr);
        chk("data0", int'(oDATA_0), e_data[0]);
        chk("data1", int'(oDATA_1), e_data[1]);
        chk("data2", int'(oDATA_2), e_data[2]);
        chk("data3", int'(oDATA_3), e_data[3]);
    endtask

    task automatic cycle(input bit st, input bit last, input bit sc, input bit v,
                         input int y0, input int y1, input int y2, input int y3);
        iSTART = st; iST_LAST = last; iSCALE = sc; iVALID = v;
        iY_0 = y0[D-1:0]; iY_1 = y1[D-1:0]; iY_2 = y2[D-1:0]; iY_3 = y3[D-1:0];
        model_step(st, last, sc, v, y0, y1, y2, y3);
        @(posedge iCLK);
        #1;
        check_all();
        iSTART = 0; iVALID = 0;
    endtask

    task automatic valid_small();
        cycle(0, 0, 0, 1, rand_y(-32767, 32767), rand_y(-32767, 32767),
              rand_y(-32767, 32767), rand_y(-32767, 32767));
    endtask

    initial begin
        scale_tab[0] = '{y: 5,      exp_data: 3};
        scale_tab[1] = '{y: -5,     exp_data: -2};
        scale_tab[2] = '{y: 65535,  exp_data: 32768};
        scale_tab[3] = '{y: -65536, exp_data: -32768};
        rev_tab[0]   = '{n: 1,   exp_addr: 8'h80};
        rev_tab[1]   = '{n: 3,   exp_addr: 8'hC0};
        rev_tab[2]   = '{n: 254, exp_addr: 8'h7F};

        // Reset state
        model_reset();
        #2 iRESET = 1'b0;
        #1 check_all();
        repeat (2) @(posedge iCLK);
        #1 check_all();
        @(negedge iCLK);
        iRESET = 1'b1;

        // Linear stage, y_k = 4n+k
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < N; n++) begin
            cycle(0, 0, 0, 1, 4*n, 4*n+1, 4*n+2, 4*n+3);
            if (n == N - 1) chk("linear_last_done", int'(oSTAGE_DONE), 1);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("linear_busy_off", int'(oBUSY), 0);

        // Last stage: bit-reversed addresses
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < N; n++) begin
            valid_small();
            for (int i = 0; i < 3; i++)
                if (rev_tab[i].n == n) chk("bitrev_addr", int'(oWR_ADDR), rev_tab[i].exp_addr);
        end
        chk("ovf_small_inputs", int'(oOVF), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Scaling table, then finish the stage with full-range data
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, scale_tab[i].y, scale_tab[i].y, scale_tab[i].y, scale_tab[i].y);
            chk("scaled_data0", int'(oDATA_0), scale_tab[i].exp_data);
            chk("scaled_data3", int'(oDATA_3), scale_tab[i].exp_data);
        end
        for (int n = 4; n < N; n++)
            cycle(0, 0, 0, 1, rand_y(-65536, 65535), rand_y(-65536, 65535),
                  rand_y(-65536, 65535), rand_y(-65536, 65535));
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Overflow set at n=10, held through DONE/IDLE, cleared by next start
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < N; n++) begin
            if (n == 10) begin
                cycle(0, 0, 0, 1, 1, 2, 32768, 3);
                chk("ovf_set", int'(oOVF), 1);
            end else begin
                valid_small();
                if (n == 9) chk("ovf_before", int'(oOVF), 0);
            end
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_held", int'(oOVF), 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_cleared", int'(oOVF), 0);
        for (int n = 0; n < N; n++) valid_small();
        chk("ovf_clean_stage", int'(oOVF), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Gapped valid with ignored starts mid-run
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * N; i++)
            cycle((i == 101) || (i == 200), 1, 1, (i % 2) == 0,
                  rand_y(-65536, 65535), rand_y(-65536, 65535), 7, -7);
        // Valids in IDLE, then start coinciding with valid
        repeat (3) cycle(0, 0, 0, 1, 11, 12, 13, 14);
        chk("idle_valid_no_write", int'(oWR_EN), 0);
        cycle(1, 0, 0, 1, 21, 22, 23, 24);
        chk("start_valid_no_write", int'(oWR_EN), 0);
        cycle(0, 0, 0, 1, 31, 32, 33, 34);
        chk("start_valid_first_addr", int'(oWR_ADDR), 0);
        chk("start_valid_first_data", int'(oDATA_0), 31);

        // Randomized traffic
        for (int i = 0; i < 2500; i++)
            cycle(($urandom % 20) == 0, 1'($urandom), 1'($urandom), ($urandom % 10) < 7,
                  rand_y(-65536, 65535), rand_y(-65536, 65535),
                  rand_y(-65536, 65535), rand_y(-65536, 65535));

        // Drain to idle (bounded), then reset at counter=100
        for (int i = 0; i < 2 * N && (m_in_stage || m_finishing); i++) valid_small();
        chk("drained_to_idle", int'(oBUSY), 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 100; n++) valid_small();
        iRESET = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge iCLK);
        iRESET = 1'b1;
        cycle(0, 0, 0, 1, 5, 5, 5, 5);
        chk("post_reset_no_write", int'(oWR_EN), 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 9, 8, 7, 6);
        chk("restart_addr", int'(oWR_ADDR), 0);
        chk("restart_wr_en", int'(oWR_EN), 1);
        chk("restart_data1", int'(oDATA_1), 8);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
